// File: rtl/axi4_sub_mem_if.sv
// axi4_bus_if: AXI4 bus bundle carrying every AW/W/B/AR/R field at the configured widths.
// Modports:
//   master - drives AW/W/AR requests and B/R ready, samples responses.
//   slave  - samples requests, drives AW/W/AR ready and the B/R response channels.
interface axi4_bus_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 9,
  parameter int unsigned AXI_USER_WIDTH = 5
);
  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

  // Write address channel
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;
  // Write data channel
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [StrbW-1:0]          w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;
  // Write response channel
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;
  // Read address channel
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;
  // Read data channel
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_sub_mem.sv
// axi4_sub_mem: AXI4 subordinate backed by an internal word-addressed memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, so one write and one read burst can overlap.
// Ports:
//   clk_i      - clock
//   rstn_i     - asynchronous active-low reset (memory contents are not reset)
//   axi_sub_if - axi4_bus_if.slave, full AXI4 subordinate side
//   wr_err_o   - one-cycle pulse after a B response with non-OKAY resp is accepted
//   rd_err_o   - one-cycle pulse after a final R beat with non-OKAY resp is accepted
// Build option: define AXI4_SUB_MEM_STALL_EN to insert LFSR-driven w_ready/r_valid bubbles.
module axi4_sub_mem #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 9,
  parameter int unsigned AXI_USER_WIDTH = 5,
  parameter int unsigned MEM_WORDS      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h5000
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  axi4_bus_if.slave axi_sub_if,
  output logic      wr_err_o,
  output logic      rd_err_o
);
  localparam int unsigned Bytes = AXI_DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam int unsigned IdxW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // One extra bit so a burst near the top of the address map cannot wrap back into range.
  localparam int unsigned CalcW = AXI_ADDR_WIDTH + 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  function automatic logic [1:0] req_check(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                           input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst, input logic atop_nz);
    logic [CalcW-1:0] a, burst_end, limit;
    logic [1:0]       res;
    a         = CalcW'(addr);
    burst_end = a + (CalcW'(len) + CalcW'(1)) * CalcW'(Bytes);
    limit     = CalcW'(BASE_ADDR) + CalcW'(MEM_WORDS) * CalcW'(Bytes);
    if (a < CalcW'(BASE_ADDR) || burst_end > limit) begin
      res = RespDecerr;
    end else if (size != 3'(OffW) || burst == BurstWrap || atop_nz) begin
      res = RespSlverr;
    end else begin
      res = RespOkay;
    end
    return res;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = (addr - BASE_ADDR) >> OffW;
    return off[IdxW-1:0];
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Backpressure source
  logic stall_d;
`ifdef AXI4_SUB_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
  // Ready/valid are registered, so the stall decision looks at the value the LFSR will hold.
  assign stall_d = (lfsr_d[1:0] == 2'b00);
`else
  assign stall_d = 1'b0;
`endif

  // ---------------------------------------------------------------- write path
  w_state_e                w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [IdxW-1:0]         w_idx_q, w_idx_d;
  logic [7:0]              w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic                    w_fixed_q, w_fixed_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic                    aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic                    b_valid_q, b_valid_d, wr_err_q, wr_err_d;
  logic                    aw_hs, w_hs, b_hs, mem_we;

  assign aw_hs = axi_sub_if.aw_valid & aw_ready_q;
  assign w_hs  = axi_sub_if.w_valid & w_ready_q;
  assign b_hs  = b_valid_q & axi_sub_if.b_ready;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_q  <= WIdle;
      w_id_q     <= '0;
      w_idx_q    <= '0;
      w_len_q    <= '0;
      w_beat_q   <= '0;
      w_fixed_q  <= 1'b0;
      b_resp_q   <= RespOkay;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_idx_q    <= w_idx_d;
      w_len_q    <= w_len_d;
      w_beat_q   <= w_beat_d;
      w_fixed_q  <= w_fixed_d;
      b_resp_q   <= b_resp_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && axi_sub_if.w_last) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_fixed_d = w_fixed_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          w_id_d    = axi_sub_if.aw_id;
          w_idx_d   = word_idx(axi_sub_if.aw_addr);
          w_len_d   = axi_sub_if.aw_len;
          w_beat_d  = '0;
          w_fixed_d = (axi_sub_if.aw_burst == BurstFixed);
          b_resp_d  = req_check(axi_sub_if.aw_addr, axi_sub_if.aw_len, axi_sub_if.aw_size,
                                axi_sub_if.aw_burst, |axi_sub_if.aw_atop);
        end
      end
      WData: begin
        if (w_hs) begin
          mem_we   = (b_resp_q == RespOkay);
          w_beat_d = w_beat_q + 8'd1;
          if (!w_fixed_q) w_idx_d = w_idx_q + IdxW'(1);
          // w_last must coincide with beat len; either mismatch degrades an OKAY burst.
          if ((axi_sub_if.w_last != (w_beat_q == w_len_q)) && (b_resp_q == RespOkay)) begin
            b_resp_d = RespSlverr;
          end
        end
      end
      default: ;
    endcase
    aw_ready_d = (w_state_d == WIdle);
    w_ready_d  = (w_state_d == WData) && !stall_d;
    b_valid_d  = (w_state_d == WResp);
    wr_err_d   = b_hs && (b_resp_q != RespOkay);
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < Bytes; b++) begin
        if (axi_sub_if.w_strb[b]) mem_q[w_idx_q][b*8 +: 8] <= axi_sub_if.w_data[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [IdxW-1:0]           r_idx_q, r_idx_d, r_idx_n, ar_idx;
  logic [7:0]                r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic                      r_fixed_q, r_fixed_d;
  logic [1:0]                r_resp_q, r_resp_d, ar_chk;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                      r_last_q, r_last_d, ar_ready_q, ar_ready_d;
  logic                      r_valid_q, r_valid_d, rd_err_q, rd_err_d;
  logic                      ar_hs, r_hs;

  assign ar_hs  = axi_sub_if.ar_valid & ar_ready_q;
  assign r_hs   = r_valid_q & axi_sub_if.r_ready;
  assign ar_idx = word_idx(axi_sub_if.ar_addr);
  assign ar_chk = req_check(axi_sub_if.ar_addr, axi_sub_if.ar_len, axi_sub_if.ar_size,
                            axi_sub_if.ar_burst, 1'b0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state_q  <= RIdle;
      r_id_q     <= '0;
      r_idx_q    <= '0;
      r_len_q    <= '0;
      r_beat_q   <= '0;
      r_fixed_q  <= 1'b0;
      r_resp_q   <= RespOkay;
      r_data_q   <= '0;
      r_last_q   <= 1'b0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_idx_q    <= r_idx_d;
      r_len_q    <= r_len_d;
      r_beat_q   <= r_beat_d;
      r_fixed_q  <= r_fixed_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      r_last_q   <= r_last_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RData;
      RData:   if (r_hs && r_last_q) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Data changes only on a handshake, so it stays stable across stall bubbles.
  always_comb begin
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_fixed_d = r_fixed_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    r_last_d  = r_last_q;
    r_idx_n   = r_fixed_q ? r_idx_q : r_idx_q + IdxW'(1);
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_id_d    = axi_sub_if.ar_id;
          r_idx_d   = ar_idx;
          r_len_d   = axi_sub_if.ar_len;
          r_beat_d  = '0;
          r_fixed_d = (axi_sub_if.ar_burst == BurstFixed);
          r_resp_d  = ar_chk;
          r_data_d  = (ar_chk == RespOkay) ? mem_q[ar_idx] : '0;
          r_last_d  = (axi_sub_if.ar_len == 8'd0);
        end
      end
      RData: begin
        if (r_hs) begin
          if (r_last_q) begin
            r_last_d = 1'b0;
          end else begin
            r_idx_d  = r_idx_n;
            r_beat_d = r_beat_q + 8'd1;
            r_data_d = (r_resp_q == RespOkay) ? mem_q[r_idx_n] : '0;
            r_last_d = ((r_beat_q + 8'd1) == r_len_q);
          end
        end
      end
      default: ;
    endcase
    ar_ready_d = (r_state_d == RIdle);
    r_valid_d  = (r_state_d == RData) && !stall_d;
    rd_err_d   = r_hs && r_last_q && (r_resp_q != RespOkay);
  end

  // ------------------------------------------------------------------ outputs
  assign axi_sub_if.aw_ready = aw_ready_q;
  assign axi_sub_if.w_ready  = w_ready_q;
  assign axi_sub_if.b_valid  = b_valid_q;
  assign axi_sub_if.b_id     = w_id_q;
  assign axi_sub_if.b_resp   = b_resp_q;
  assign axi_sub_if.b_user   = '0;
  assign axi_sub_if.ar_ready = ar_ready_q;
  assign axi_sub_if.r_valid  = r_valid_q;
  assign axi_sub_if.r_id     = r_id_q;
  assign axi_sub_if.r_data   = r_data_q;
  assign axi_sub_if.r_resp   = r_resp_q;
  assign axi_sub_if.r_last   = r_last_q;
  assign axi_sub_if.r_user   = '0;
  assign wr_err_o            = wr_err_q;
  assign rd_err_o            = rd_err_q;

  // Request attributes this memory has no use for.
  logic unused_sigs;
  assign unused_sigs = ^{axi_sub_if.aw_lock, axi_sub_if.aw_cache, axi_sub_if.aw_prot,
                         axi_sub_if.aw_qos, axi_sub_if.aw_region, axi_sub_if.aw_user,
                         axi_sub_if.w_user, axi_sub_if.ar_lock, axi_sub_if.ar_cache,
                         axi_sub_if.ar_prot, axi_sub_if.ar_qos, axi_sub_if.ar_region,
                         axi_sub_if.ar_user};
endmodule
